shunt_fringe_payload_packer: RTL and testbench

//  Multi-channel Fringe signal-to-payload segmenter in the Fringe TCP transmit path.

---
 rtl/shunt_fringe_payload_packer.sv | 154 +++++++++++++++
 tb/tb_shunt_fringe_payload_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shunt_fringe_payload_packer.sv
// Round-robin multi-channel signal-to-payload segmenter with per-channel event counters.
// Optional X/Z mask path enabled by defining FRNG_LOGIC_PAYLOAD_EN.
module shunt_fringe_payload_packer #(
  parameter int N_CH      = 2,
  parameter int SIG_W     = 1024,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 32,
  localparam int N_BEATS  = (SIG_W + PAYLOAD_W - 1) / PAYLOAD_W,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int SZ_W     = $clog2(SIG_W + 1),
  localparam int IX_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [N_CH-1:0]        ch_ready,
  input  logic [N_CH*SIG_W-1:0]  ch_data,
  input  logic [N_CH*SZ_W-1:0]   ch_size,
`ifdef FRNG_LOGIC_PAYLOAD_EN
  input  logic [N_CH*SIG_W-1:0]  ch_xz,
  output logic [PAYLOAD_W-1:0]   out_xz,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic [IX_W-1:0]        out_idx,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_hdr_only,
  output logic [N_CH*CNT_W-1:0]  event_cnt,
  output logic                   busy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                       r_state, w_next;
  logic [CH_W-1:0]              r_rr, r_ch, w_grant;
  logic                         w_found, w_accept, w_send, w_is_last;
  logic [IX_W-1:0]              r_idx, r_last_idx, w_last_idx;
  logic [SZ_W-1:0]              r_size, w_sel_size, w_clamp;
  logic [SIG_W-1:0]             w_sel_data;
  logic [N_BEATS*PAYLOAD_W-1:0] r_data;
  logic [PAYLOAD_W-1:0]         w_seg, w_mask;
  logic [CNT_W-1:0]             r_cnt [N_CH];
  int                           w_rem;

  // Search from the round-robin pointer upward, wrapping at N_CH.
  always_comb begin
    int c;
    c       = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      c = int'(r_rr) + i;
      if (c >= N_CH) c = c - N_CH;
      if (!w_found && ch_valid[c]) begin
        w_grant = CH_W'(c);
        w_found = 1'b1;
      end
    end
  end

  assign w_sel_data = ch_data[w_grant*SIG_W +: SIG_W];
  assign w_sel_size = ch_size[w_grant*SZ_W +: SZ_W];
  assign w_clamp    = (w_sel_size > SZ_W'(SIG_W)) ? SZ_W'(SIG_W) : w_sel_size;
  assign w_last_idx = (w_clamp == '0) ? '0 : IX_W'((int'(w_clamp) - 1) / PAYLOAD_W);
  assign w_send     = (r_state == S_SEND);
  assign w_is_last  = (r_idx == r_last_idx);

  always_comb begin
    w_next    = r_state;
    ch_ready  = '0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          ch_ready[w_grant] = 1'b1;
          w_accept          = 1'b1;
          w_next            = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready && w_is_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_ch       <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_size     <= '0;
      for (int c = 0; c < N_CH; c++) r_cnt[c] <= '0;
    end else if (w_accept) begin
      r_rr       <= (w_grant == CH_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
      r_ch       <= w_grant;
      r_idx      <= '0;
      r_last_idx <= w_last_idx;
      r_size     <= w_clamp;
    end else if (out_valid && out_ready) begin
      if (w_is_last) r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
      else           r_idx       <= r_idx + 1'b1;
    end
  end

  // Payload storage is zero-extended to whole beats so the top beat pads with zeros.
  always_ff @(posedge clk) begin
    if (w_accept) r_data <= (N_BEATS*PAYLOAD_W)'(w_sel_data);
  end

  assign w_seg = r_data[r_idx*PAYLOAD_W +: PAYLOAD_W];

  always_comb begin
    w_rem = int'(r_size) - int'(r_idx) * PAYLOAD_W;
    for (int b = 0; b < PAYLOAD_W; b++) w_mask[b] = (b < w_rem);
  end

  assign out_data     = w_send ? (w_seg & w_mask) : '0;
  assign out_ch       = w_send ? r_ch : '0;
  assign out_idx      = w_send ? r_idx : '0;
  assign out_first    = w_send && (r_idx == '0);
  assign out_last     = w_send && w_is_last;
  assign out_hdr_only = w_send && (r_size == '0);

  always_comb begin
    event_cnt = '0;
    for (int c = 0; c < N_CH; c++) event_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
  end

`ifdef FRNG_LOGIC_PAYLOAD_EN
  logic [N_BEATS*PAYLOAD_W-1:0] r_xz;
  logic [PAYLOAD_W-1:0]         w_xseg;

  always_ff @(posedge clk) begin
    if (w_accept) r_xz <= (N_BEATS*PAYLOAD_W)'(ch_xz[w_grant*SIG_W +: SIG_W]);
  end

  assign w_xseg = r_xz[r_idx*PAYLOAD_W +: PAYLOAD_W];
  assign out_xz = w_send ? (w_xseg & w_mask) : '0;
`endif

endmodule

// File: tb/tb_shunt_fringe_payload_packer.sv
// Directed bench for shunt_fringe_payload_packer: reset, segmentation, header-only,
// round-robin order, backpressure stability and 4-bit event counter wrap.
module tb_shunt_fringe_payload_packer;
  localparam int N_CH  = 2;
  localparam int SIG_W = 1024;
  localparam int PW    = 64;
  localparam int CNT_W = 4;
  localparam int SZ_W  = 11;
  localparam int IX_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       ch_valid;
  logic [N_CH-1:0]       ch_ready;
  logic [N_CH*SIG_W-1:0] ch_data;
  logic [N_CH*SZ_W-1:0]  ch_size;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [PW-1:0]         out_data;
  logic                  out_ch;
  logic [IX_W-1:0]       out_idx;
  logic                  out_first, out_last, out_hdr_only;
  logic [N_CH*CNT_W-1:0] event_cnt;
  logic                  busy;
`ifdef FRNG_LOGIC_PAYLOAD_EN
  logic [N_CH*SIG_W-1:0] ch_xz;
  logic [PW-1:0]         out_xz;
`endif

  shunt_fringe_payload_packer #(
    .N_CH(N_CH), .SIG_W(SIG_W), .PAYLOAD_W(PW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .ch_size(ch_size),
`ifdef FRNG_LOGIC_PAYLOAD_EN
    .ch_xz(ch_xz), .out_xz(out_xz),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .out_hdr_only(out_hdr_only), .event_cnt(event_cnt), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]   d;
    logic [PW-1:0]   x;
    logic            ch;
    logic [IX_W-1:0] idx;
    logic            f, l, h;
    int              cyc;
  } beat_t;

  int     n_chk = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  logic   bp_en = 1'b0;
  beat_t  bq[$];
  int     aq_ch[$];
  int     aq_cyc[$];
  logic   stall_p = 1'b0;
  logic [71:0] snap;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SIG_W-1:0] pat();
    logic [SIG_W-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*PW +: PW] = {16'hDEAD, 16'(k), 16'hBEEF, 16'(k)};
    return v;
  endfunction

  // Monitor: grants, accepted beats, and field stability during stalls.
  always @(negedge clk) begin : mon
    beat_t b;
    logic [71:0] cur;
    cyc++;
    cur = {out_data, out_ch, out_idx, out_first, out_last, out_hdr_only};
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (|(ch_valid & ch_ready)) begin
        aq_ch.push_back(ch_ready[1] ? 1 : 0);
        aq_cyc.push_back(cyc);
      end
      if (stall_p && out_valid) chk("stall_stable", 128'(cur), 128'(snap));
      if (out_valid && out_ready) begin
        b.d = out_data; b.ch = out_ch; b.idx = out_idx;
        b.f = out_first; b.l = out_last; b.h = out_hdr_only; b.cyc = cyc;
`ifdef FRNG_LOGIC_PAYLOAD_EN
        b.x = out_xz;
`else
        b.x = '0;
`endif
        bq.push_back(b);
      end
      stall_p = out_valid && !out_ready;
      snap    = cur;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = bp_en ? ($urandom_range(0, 9) == 0) : 1'b1;
  end

  task automatic clear_q();
    bq.delete(); aq_ch.delete(); aq_cyc.delete();
  endtask

  task automatic send_value(input int c, input logic [SIG_W-1:0] d, input int sz);
    logic ok;
    ch_data[c*SIG_W +: SIG_W] = d;
    ch_size[c*SZ_W +: SZ_W]   = SZ_W'(sz);
    ch_valid[c]               = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (ch_ready[c]) ok = 1'b1;
    end
    chk("accept_seen", 128'(ok), 128'(1));
    @(posedge clk); #1;
    ch_valid[c] = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (bq.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("beats_arrived", 128'(bq.size()), 128'(n));
    @(posedge clk); #1;
  endtask

  initial begin
    logic hit;
    int   c0, c1;
    rst_n = 1'b0; ch_valid = '0; ch_data = '0; ch_size = '0;
`ifdef FRNG_LOGIC_PAYLOAD_EN
    ch_xz = '0;
`endif
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ch_ready", 128'(ch_ready), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_flags", 128'({out_first, out_last, out_hdr_only}), 128'(0));
    chk("rst_event_cnt", 128'(event_cnt), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of an 8-beat value
    send_value(0, pat(), 512);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == 4'd2) hit = 1'b1;
    end
    chk("mid_reach_beat2", 128'(hit), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 128'(out_valid), 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_out_data", 128'(out_data), 128'(0));
    chk("mid_out_idx_ch", 128'({out_idx, out_ch}), 128'(0));
    chk("mid_flags", 128'({out_first, out_last, out_hdr_only}), 128'(0));
    chk("mid_event_cnt", 128'(event_cnt), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();

    // full 1024-bit value
    send_value(0, pat(), 1024);
    wait_beats(16);
    for (int k = 0; k < 16; k++) begin
      chk("single_data", 128'(bq[k].d), 128'({16'hDEAD, 16'(k), 16'hBEEF, 16'(k)}));
      chk("single_idx", 128'(bq[k].idx), 128'(k));
      chk("single_flags", 128'({bq[k].ch, bq[k].f, bq[k].l, bq[k].h}),
          128'({1'b0, k == 0, k == 15, 1'b0}));
    end
    chk("single_latency", 128'(bq[0].cyc - aq_cyc[0]), 128'(1));
    chk("single_cnt0", 128'(event_cnt[3:0]), 128'(1));
    clear_q();

    // header-only
    send_value(0, pat(), 0);
    wait_beats(1);
    chk("hdr_data", 128'(bq[0].d), 128'(0));
    chk("hdr_flags", 128'({bq[0].idx, bq[0].f, bq[0].l, bq[0].h}), 128'({4'd0, 3'b111}));
    chk("hdr_cnt0", 128'(event_cnt[3:0]), 128'(2));
    clear_q();

    // partial last beat
    send_value(1, '1, 70);
    wait_beats(2);
    chk("part_beat0", 128'(bq[0].d), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("part_beat1", 128'(bq[1].d), 128'(64'h3F));
    chk("part_flags0", 128'({bq[0].ch, bq[0].f, bq[0].l, bq[0].h}), 128'(4'b1100));
    chk("part_flags1", 128'({bq[1].ch, bq[1].f, bq[1].l, bq[1].h}), 128'(4'b1010));
    chk("part_cnt1", 128'(event_cnt[7:4]), 128'(1));
    clear_q();

    // both channels requesting continuously, three values each
    ch_data[0 +: SIG_W]     = {SIG_W/8{8'hC0}};
    ch_data[SIG_W +: SIG_W] = {SIG_W/8{8'hC1}};
    ch_size = {SZ_W'(64), SZ_W'(64)};
    ch_valid = 2'b11;
    for (int n = 0; n < 400 && ch_valid != 2'b00; n++) begin
      @(posedge clk); #1;
      c0 = 0; c1 = 0;
      foreach (aq_ch[i]) if (aq_ch[i] == 0) c0++; else c1++;
      if (c0 >= 3) ch_valid[0] = 1'b0;
      if (c1 >= 3) ch_valid[1] = 1'b0;
    end
    wait_beats(6);
    for (int i = 0; i < 6; i++) begin
      chk("arb_grant", 128'(aq_ch[i]), 128'(i % 2));
      chk("arb_out_ch", 128'(bq[i].ch), 128'(i % 2));
      chk("arb_data", 128'(bq[i].d), (i % 2) ? 128'({8{8'hC1}}) : 128'({8{8'hC0}}));
    end
    chk("arb_cnt", 128'(event_cnt), 128'({4'd4, 4'd5}));
    clear_q();

    // random backpressure; ch1 reaches its 16th value and wraps
    bp_en = 1'b1;
    for (int v = 0; v < 12; v++) send_value(1, '1, 70);
    wait_beats(24);
    bp_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("bp_data", 128'(bq[i].d), (i % 2) ? 128'(64'h3F) : 128'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("bp_idx_last", 128'({bq[i].idx, bq[i].l}), 128'({4'(i % 2), (i % 2) == 1}));
    end
    chk("bp_cnt_wrap", 128'(event_cnt), 128'({4'd0, 4'd5}));
    clear_q();

`ifdef FRNG_LOGIC_PAYLOAD_EN
    ch_xz = '0;
    ch_xz[65] = 1'b1;
    send_value(0, '1, 70);
    wait_beats(2);
    chk("xz_beat0", 128'(bq[0].x), 128'(0));
    chk("xz_beat1", 128'(bq[1].x), 128'(64'h2));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
